// File: rtl/imm_decode_ctrl.sv
// imm_decode_ctrl
// Decode-stage sequencer in front of the RV32I immediate extender. Fetched
// instructions arrive on a valid/ready handshake and are held in a 2-entry
// queue. The opcode is decoded when an entry is written, so every head output
// comes straight from a register.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  fetch-side handshake; in_instr, in_pc carry the payload
//   flush              drop everything buffered and refuse the offered word
//   out_valid/out_ready ID/EX-side handshake (out_ready low = stall)
//   out_instr, out_pc  head instruction and its PC
//   imm                head instr[31:7] for the extender
//   ImmSrc             extender format select (0 I, 1 S, 2 B, 3 J, 4 U)
//   imm_used           head instruction consumes an immediate
//   illegal            head opcode is not RV32I
//   illegal_cnt        saturating count of illegal instructions popped
module imm_decode_ctrl #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [PC_W-1:0]  out_pc,
    output logic [24:0]      imm,
    output logic [2:0]       ImmSrc,
    output logic             imm_used,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [31:0]      instr_mem [2];
    logic [PC_W-1:0]  pc_mem    [2];
    logic [2:0]       src_mem   [2];
    logic             used_mem  [2];
    logic             ill_mem   [2];

    logic [1:0]       count_reg;
    logic             rd_ptr_reg;
    logic             wr_ptr_reg;
    logic [CNT_W-1:0] illegal_cnt_reg;

    logic             push;
    logic             pop;
    logic [2:0]       dec_src;
    logic             dec_used;
    logic             dec_ill;

    // rst_n gates in_ready so fetch sees "not ready" while reset is held.
    assign in_ready  = rst_n & ~flush & (count_reg != 2'd2);
    assign out_valid = (count_reg != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        dec_src  = 3'd0;
        dec_used = 1'b0;
        dec_ill  = 1'b0;
        case (in_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111,
            7'b0001111, 7'b1110011: begin dec_src = 3'd0; dec_used = 1'b1; end
            7'b0100011:             begin dec_src = 3'd1; dec_used = 1'b1; end
            7'b1100011:             begin dec_src = 3'd2; dec_used = 1'b1; end
            7'b1101111:             begin dec_src = 3'd3; dec_used = 1'b1; end
            7'b0110111, 7'b0010111: begin dec_src = 3'd4; dec_used = 1'b1; end
            7'b0110011:             begin dec_src = 3'd0; dec_used = 1'b0; end
            default:                dec_ill = 1'b1;
        endcase
    end

    // One register slice per queue entry; cleared on reset so the head
    // outputs read zero while the queue is empty after reset.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    instr_mem[gi] <= '0;
                    pc_mem[gi]    <= '0;
                    src_mem[gi]   <= '0;
                    used_mem[gi]  <= 1'b0;
                    ill_mem[gi]   <= 1'b0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    instr_mem[gi] <= in_instr;
                    pc_mem[gi]    <= in_pc;
                    src_mem[gi]   <= dec_src;
                    used_mem[gi]  <= dec_used;
                    ill_mem[gi]   <= dec_ill;
                end
            end
        end
    endgenerate

    // push is already blocked by flush through in_ready; only pop needs the
    // explicit flush priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= 2'd0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
        end else if (flush) begin
            count_reg  <= 2'd0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt_reg <= '0;
        end else if (pop && !flush && ill_mem[rd_ptr_reg] && (illegal_cnt_reg != '1)) begin
            illegal_cnt_reg <= illegal_cnt_reg + 1'b1;
        end
    end

    assign out_instr   = instr_mem[rd_ptr_reg];
    assign out_pc      = pc_mem[rd_ptr_reg];
    assign imm         = instr_mem[rd_ptr_reg][31:7];
    assign ImmSrc      = src_mem[rd_ptr_reg];
    assign imm_used    = used_mem[rd_ptr_reg];
    assign illegal     = ill_mem[rd_ptr_reg];
    assign illegal_cnt = illegal_cnt_reg;

endmodule

// File: tb/tb_imm_decode_ctrl.sv
module tb_imm_decode_ctrl;

    localparam int PC_W  = 32;
    localparam int CNT_W = 2;   // small counter so saturation is reachable

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [PC_W-1:0]  in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic [PC_W-1:0]  out_pc;
    logic [24:0]      imm;
    logic [2:0]       ImmSrc;
    logic             imm_used;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    imm_decode_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .imm        (imm),
        .ImmSrc     (ImmSrc),
        .imm_used   (imm_used),
        .illegal    (illegal),
        .illegal_cnt(illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic        used;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        logic [2:0]      src;
        logic            used;
        logic            ill;
    } exp_t;

    vec_t tbl [12];
    exp_t sb [$];
    int   model_cnt;
    int   errors;
    int   checks;
    logic [PC_W-1:0] pc_ctr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered just after a rising edge. Drives inputs, checks outputs at the
    // falling edge against the model, then advances the model past the edge.
    task automatic cycle(input logic v, input int idx, input logic ordy, input logic fl);
        logic exp_ready;
        logic do_push;
        logic do_pop;
        exp_t e;
        in_valid  = v;
        in_instr  = tbl[idx].instr;
        in_pc     = pc_ctr;
        out_ready = ordy;
        flush     = fl;
        #4;
        exp_ready = !fl && (sb.size() < 2);
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        chk("illegal_cnt", 64'(illegal_cnt), 64'(model_cnt));
        if (sb.size() != 0) begin
            chk("out_instr", 64'(out_instr), 64'(sb[0].instr));
            chk("out_pc", 64'(out_pc), 64'(sb[0].pc));
            chk("imm", 64'(imm), 64'(sb[0].instr[31:7]));
            chk("ImmSrc", 64'(ImmSrc), 64'(sb[0].src));
            chk("imm_used", 64'(imm_used), 64'(sb[0].used));
            chk("illegal", 64'(illegal), 64'(sb[0].ill));
        end
        do_push = v && exp_ready;
        do_pop  = (sb.size() != 0) && ordy;
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
        end else begin
            if (do_pop) begin
                $display("pop  instr=0x%08h pc=0x%08h src=%0d used=%0b ill=%0b",
                         sb[0].instr, sb[0].pc, sb[0].src, sb[0].used, sb[0].ill);
                if (sb[0].ill && model_cnt < (1 << CNT_W) - 1) model_cnt++;
                void'(sb.pop_front());
            end
            if (do_push) begin
                e.instr = tbl[idx].instr;
                e.pc    = pc_ctr;
                e.src   = tbl[idx].src;
                e.used  = tbl[idx].used;
                e.ill   = tbl[idx].ill;
                sb.push_back(e);
                pc_ctr  = pc_ctr + 4;
            end
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd0);
        chk("rst illegal_cnt", 64'(illegal_cnt), 64'd0);
        chk("rst out_instr", 64'(out_instr), 64'd0);
        chk("rst out_pc", 64'(out_pc), 64'd0);
    endtask

    initial begin
        tbl[0]  = '{32'h00500093, 3'd0, 1'b1, 1'b0}; // addi
        tbl[1]  = '{32'h00112023, 3'd1, 1'b1, 1'b0}; // sw
        tbl[2]  = '{32'hFE000EE3, 3'd2, 1'b1, 1'b0}; // beq
        tbl[3]  = '{32'h008000EF, 3'd3, 1'b1, 1'b0}; // jal
        tbl[4]  = '{32'h123452B7, 3'd4, 1'b1, 1'b0}; // lui
        tbl[5]  = '{32'h00000000, 3'd0, 1'b0, 1'b1}; // illegal
        tbl[6]  = '{32'h002081B3, 3'd0, 1'b0, 1'b0}; // add
        tbl[7]  = '{32'h00001517, 3'd4, 1'b1, 1'b0}; // auipc
        tbl[8]  = '{32'h00000073, 3'd0, 1'b1, 1'b0}; // ecall
        tbl[9]  = '{32'h0002A303, 3'd0, 1'b1, 1'b0}; // lw
        tbl[10] = '{32'h0000000F, 3'd0, 1'b1, 1'b0}; // fence
        tbl[11] = '{32'h000080E7, 3'd0, 1'b1, 1'b0}; // jalr

        errors = 0; checks = 0; model_cnt = 0; pc_ctr = 32'h0000_1000;
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;

        // Reset state
        @(posedge clk); #1;
        check_reset_outputs();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Stream every table vector at full throughput
        for (int i = 0; i < 12; i++) cycle(1'b1, i, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);

        // Stall / full, then drain
        cycle(1'b1, 0, 1'b0, 1'b0);
        cycle(1'b1, 1, 1'b0, 1'b0);
        cycle(1'b1, 2, 1'b0, 1'b0);   // refused: queue full
        cycle(1'b0, 0, 1'b0, 1'b0);   // head held stable
        cycle(1'b1, 2, 1'b1, 1'b0);   // pop A; no pass-through while full
        cycle(1'b0, 0, 1'b1, 1'b0);   // pop B, in_ready back up
        cycle(1'b0, 0, 1'b1, 1'b0);

        // Simultaneous push and pop at count 1
        cycle(1'b1, 3, 1'b0, 1'b0);
        cycle(1'b1, 4, 1'b1, 1'b0);
        cycle(1'b1, 6, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);

        // Flush with two illegal entries buffered plus an offer and a pop
        cycle(1'b1, 5, 1'b0, 1'b0);
        cycle(1'b1, 5, 1'b0, 1'b0);
        cycle(1'b1, 7, 1'b1, 1'b1);
        cycle(1'b0, 0, 1'b1, 1'b0);
        chk("cnt after flush", 64'(illegal_cnt), 64'd1);

        // Counter saturation: four more illegal pops on a 2-bit counter
        for (int i = 0; i < 4; i++) cycle(1'b1, 5, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        chk("cnt saturated", 64'(illegal_cnt), 64'd3);

        // Asynchronous reset in the middle of a stall
        cycle(1'b1, 8, 1'b0, 1'b0);
        cycle(1'b1, 9, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        sb.delete();
        model_cnt = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(1'b1, 10, 1'b1, 1'b0);
        cycle(1'b1, 11, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
